// File: rtl/imem_responder.sv
// Memory-side responder for the cache refill port: single-word reads from a
// preloadable word array, with a shorter latency for next-word (page-mode) accesses.
module imem_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 4,
  parameter int          SEQ_LATENCY = 1,
  parameter logic [31:0] OOR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        oor_error,
  output logic [31:0] access_count
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Preloaded from outside via the hierarchical name <inst>.memory.
  logic [31:0] memory [MEM_WORDS];

  state_t      state;
  logic [31:0] idx, last_idx, cnt, req_idx;
  logic        last_valid, oor, seq;

  // Modular subtract: addresses below BASE_ADDR wrap to huge indices and land out of range.
  assign req_idx = (mem_addr - BASE_ADDR) >> 2;
  assign seq     = last_valid && (req_idx == last_idx + 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_ready    <= 1'b0;
      mem_rdata    <= '0;
      oor_error    <= 1'b0;
      access_count <= '0;
      last_valid   <= 1'b0;
      last_idx     <= '0;
      idx          <= '0;
      cnt          <= '0;
      oor          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_valid) begin
          idx   <= req_idx;
          oor   <= (req_idx >= 32'(MEM_WORDS));
          cnt   <= seq ? 32'(SEQ_LATENCY - 1) : 32'(LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (!mem_valid) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 32'd1;
          end else begin
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_rdata <= oor ? OOR_DATA : memory[idx[AW-1:0]];
          end
        end
        RESP: begin
          // Requester still shows the served request here; going to IDLE avoids recapture.
          state        <= IDLE;
          mem_ready    <= 1'b0;
          mem_rdata    <= '0;
          access_count <= (access_count == 32'hFFFF_FFFF) ? access_count
                                                          : access_count + 32'd1;
          last_idx     <= idx;
          last_valid   <= 1'b1;
          oor_error    <= oor_error | oor;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, sequential detection, OOR, abort, reset.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        oor_error;
  logic [31:0] access_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  imem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .oor_error    (oor_error),
    .access_count (access_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves at the negedge after the RESP->IDLE edge.
  // Cycles counts negedges from assertion until ready is seen (= lat+1).
  task automatic do_req(input string tag, input logic [31:0] addr,
                        input int exp_cyc, input logic [31:0] exp_data);
    int n = 0;
    mem_valid = 1'b1;
    mem_addr  = addr;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 30);
    chk({tag, " cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, " rdata"}, mem_rdata, exp_data);
    mem_valid = 1'b0;
    @(negedge clk);
    exp_cnt++;
    chk({tag, " pulse"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, " rdata0"}, mem_rdata, 32'd0);
    chk({tag, " count"}, access_count, 32'(exp_cnt));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dut.memory[i] = 32'h1111_0000 + 32'(i);
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset ready", {31'd0, mem_ready}, 32'd0);
    chk("reset rdata", mem_rdata, 32'd0);
    chk("reset count", access_count, 32'd0);
    chk("reset oor", {31'd0, oor_error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // first access, then sequential run
    do_req("t1 0x0", 32'h0, 5, 32'h1111_0000);
    do_req("t2 0x4", 32'h4, 2, 32'h1111_0001);
    do_req("t2 0x8", 32'h8, 2, 32'h1111_0002);
    // non-sequential jump back
    do_req("t3 0x10", 32'h10, 5, 32'h1111_0004);
    do_req("t3 0x4", 32'h4, 5, 32'h1111_0001);
    // out of range, sticky error
    do_req("t4 oor", 32'h1000, 5, 32'hDEAD_BEEF);
    chk("t4 oor flag", {31'd0, oor_error}, 32'd1);
    do_req("t4 0x0", 32'h0, 5, 32'h1111_0000);
    chk("t4 oor sticky", {31'd0, oor_error}, 32'd1);

    // abort 2 cycles after capture; sequential tracking survives
    mem_valid = 1'b1; mem_addr = 32'h20;
    repeat (2) @(negedge clk);
    mem_valid = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (mem_ready) seen = 1'b1;
      end
      chk("t5 no ready", {31'd0, seen}, 32'd0);
    end
    chk("t5 count", access_count, 32'(exp_cnt));
    do_req("t5 0x4 seq", 32'h4, 2, 32'h1111_0001);

    // last word then first OOR word is still sequential
    do_req("b 0xffc", 32'hFFC, 5, 32'h1111_03FF);
    do_req("b 0x1000", 32'h1000, 2, 32'hDEAD_BEEF);
    do_req("b 0x0", 32'h0, 5, 32'h1111_0000);

    // reset during WAIT
    mem_valid = 1'b1; mem_addr = 32'h4;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("t6 ready", {31'd0, mem_ready}, 32'd0);
    chk("t6 count", access_count, 32'd0);
    chk("t6 oor", {31'd0, oor_error}, 32'd0);
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("t6 idle ready", {31'd0, mem_ready}, 32'd0);
    do_req("t6 0x4 full", 32'h4, 5, 32'h1111_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
